// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between NUM_REQ requesters. A round-robin
//   grant feeds a single-entry issue register that drives the ALU for one
//   cycle; the ALU result is then held in a response register until the
//   consumer takes it. At most one operation is in flight.
//
//   Optional build macro: ALU_ARB_PRIO0_EN
//     defined   : requester 0 always wins when valid; requesters
//                 1..NUM_REQ-1 round-robin among themselves, and a grant
//                 to requester 0 leaves the pointer alone.
//     undefined : pure round-robin over all requesters.
//
//   Ports
//     clk, rst            clock (rising edge), async active-high reset
//     ReqValid/ReqReady   per-requester handshake, ReqReady is the one-hot grant
//     ReqOp/ReqA/ReqB     packed per-requester opcode and operands
//     AluOp/AluA/AluB     issue register driven to the ALU
//     AluOut/AluZero      combinational ALU result
//     RspValid/RspReady   response handshake
//     RspId/RspData/RspZero  captured requester id, result and zero flag
module alu_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned OP_W    = 3,
    parameter int unsigned ID_W    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       ReqValid,
    input  logic [NUM_REQ*OP_W-1:0]  ReqOp,
    input  logic [NUM_REQ*WIDTH-1:0] ReqA,
    input  logic [NUM_REQ*WIDTH-1:0] ReqB,
    output logic [NUM_REQ-1:0]       ReqReady,
    output logic [OP_W-1:0]          AluOp,
    output logic [WIDTH-1:0]         AluA,
    output logic [WIDTH-1:0]         AluB,
    input  logic [WIDTH-1:0]         AluOut,
    input  logic                     AluZero,
    output logic                     RspValid,
    input  logic                     RspReady,
    output logic [ID_W-1:0]          RspId,
    output logic [WIDTH-1:0]         RspData,
    output logic                     RspZero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t             state_q;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [OP_W-1:0]    op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [ID_W-1:0]    id_q;
    logic               rsp_valid_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [WIDTH-1:0]   rsp_data_q;
    logic               rsp_zero_q;

    logic               eligible, found, accept;
    logic [NUM_REQ-1:0] rr_valid;
    logic               hi_found, lo_found;
    logic [ID_W-1:0]    hi_idx, lo_idx, gidx;
    logic [NUM_REQ-1:0] grant;
    logic [OP_W-1:0]    sel_op;
    logic [WIDTH-1:0]   sel_a, sel_b;

    // Round-robin as two priority scans: the lowest valid index at or above
    // the pointer wins; if none exists the search wraps to the lowest valid
    // index overall.
    always_comb begin
        eligible = (state_q == IDLE) || ((state_q == RESP) && RspReady);
        rr_valid = ReqValid;
`ifdef ALU_ARB_PRIO0_EN
        rr_valid[0] = 1'b0;
`endif
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (rr_valid[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = ID_W'(i);
            end
            if (rr_valid[i] && !hi_found && (i >= 32'(ptr_q))) begin
                hi_found = 1'b1;
                hi_idx   = ID_W'(i);
            end
        end
        found = hi_found | lo_found;
        gidx  = hi_found ? hi_idx : lo_idx;
`ifdef ALU_ARB_PRIO0_EN
        if (ReqValid[0]) begin
            found = 1'b1;
            gidx  = '0;
        end
`endif
        accept = eligible && found;

        grant  = '0;
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (32'(gidx) == i) begin
                grant[i] = accept;
                sel_op   = ReqOp[i*OP_W +: OP_W];
                sel_a    = ReqA[i*WIDTH +: WIDTH];
                sel_b    = ReqB[i*WIDTH +: WIDTH];
            end
        end

        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = ((32'(gidx) + 1) >= NUM_REQ) ? '0 : ID_W'(32'(gidx) + 1);
`ifdef ALU_ARB_PRIO0_EN
            // A fixed-priority win by requester 0 leaves the rotation untouched.
            if (ReqValid[0]) begin
                ptr_d = ptr_q;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            // accept is only possible in states that move to ISSUE next.
            if (accept) begin
                op_q <= sel_op;
                a_q  <= sel_a;
                b_q  <= sel_b;
                id_q <= gidx;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_valid_q <= 1'b1;
                    rsp_id_q    <= id_q;
                    rsp_data_q  <= AluOut;
                    rsp_zero_q  <= AluZero;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (RspReady) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= accept ? ISSUE : IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ReqReady = grant;
    assign AluOp    = op_q;
    assign AluA     = a_q;
    assign AluB     = b_q;
    assign RspValid = rsp_valid_q;
    assign RspId    = rsp_id_q;
    assign RspData  = rsp_data_q;
    assign RspZero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Drives alu_arbiter (NUM_REQ=3) with directed scenarios and random traffic,
//   models a simple ALU on the AluOp/AluA/AluB -> AluOut/AluZero side, and
//   compares every cycle against a transaction-level reference model.
module tb_alu_arbiter;

    localparam int N  = 3;
    localparam int W  = 16;
    localparam int OW = 3;
    localparam int IW = 2;
`ifdef ALU_ARB_PRIO0_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*OW-1:0] req_op;
    logic [N*W-1:0]  req_a, req_b;
    logic [N-1:0]    req_ready;
    logic [OW-1:0]   alu_op;
    logic [W-1:0]    alu_a, alu_b, alu_out;
    logic            alu_zero;
    logic            rsp_valid, rsp_ready, rsp_zero;
    logic [IW-1:0]   rsp_id;
    logic [W-1:0]    rsp_data;

    alu_arbiter #(.NUM_REQ(N), .WIDTH(W), .OP_W(OW), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .ReqValid(req_valid), .ReqOp(req_op), .ReqA(req_a), .ReqB(req_b),
        .ReqReady(req_ready),
        .AluOp(alu_op), .AluA(alu_a), .AluB(alu_b),
        .AluOut(alu_out), .AluZero(alu_zero),
        .RspValid(rsp_valid), .RspReady(rsp_ready),
        .RspId(rsp_id), .RspData(rsp_data), .RspZero(rsp_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_f(input logic [OW-1:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            3'd6: return a << b[3:0];
            default: return b;
        endcase
    endfunction

    assign alu_out  = alu_f(alu_op, alu_a, alu_b);
    assign alu_zero = (alu_out == '0);

    // Requester side
    logic [N-1:0]  r_v;
    logic [OW-1:0] r_op [N];
    logic [W-1:0]  r_a [N];
    logic [W-1:0]  r_b [N];
    logic [OW-1:0] fx_op [N];
    logic [W-1:0]  fx_a [N];
    logic [W-1:0]  fx_b [N];
    logic [N-1:0]  want, acc;
    bit            rnd_want, rnd_rdy, fixed;
    logic          rdy_val;

    always_comb begin
        req_op = '0;
        req_a  = '0;
        req_b  = '0;
        for (int i = 0; i < N; i++) begin
            req_op[i*OW +: OW] = r_op[i];
            req_a[i*W +: W]    = r_a[i];
            req_b[i*W +: W]    = r_b[i];
        end
    end
    assign req_valid = r_v;

    // Reference model
    typedef struct {
        int         id;
        logic [W-1:0] d;
        logic       z;
    } rsp_t;

    rsp_t          exp_q[$];
    int            ptr;
    bit            infl;
    int            fl_id;
    logic [OW-1:0] fl_op;
    logic [W-1:0]  fl_a, fl_b;

    int n_chk, n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        ptr   = 0;
        infl  = 1'b0;
        fl_id = 0;
        fl_op = '0;
        fl_a  = '0;
        fl_b  = '0;
        acc   = '0;
    endtask

    // Which requester the arbiter should grant right now, or -1.
    function automatic int pick();
        if (infl || (exp_q.size() != 0 && !rsp_ready)) return -1;
        if (PRIO && r_v[0]) return 0;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (PRIO && i == 0) continue;
            if (r_v[i]) return i;
        end
        return -1;
    endfunction

    // Check current outputs, then advance the model across the next edge.
    task automatic model_cycle();
        int g;
        logic [N-1:0] exp_rr;
        rsp_t r;
        g = pick();
        exp_rr = '0;
        if (g >= 0) exp_rr[g] = 1'b1;
        check_eq("ReqReady", 32'(req_ready), 32'(exp_rr));
        check_eq("RspValid", 32'(rsp_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check_eq("RspId", 32'(rsp_id), 32'(exp_q[0].id));
            check_eq("RspData", 32'(rsp_data), 32'(exp_q[0].d));
            check_eq("RspZero", 32'(rsp_zero), 32'(exp_q[0].z));
        end
        check_eq("AluOp", 32'(alu_op), 32'(fl_op));
        check_eq("AluA", 32'(alu_a), 32'(fl_a));
        check_eq("AluB", 32'(alu_b), 32'(fl_b));

        if (exp_q.size() != 0 && rsp_ready) void'(exp_q.pop_front());
        if (infl) begin
            r.id = fl_id;
            r.d  = alu_f(fl_op, fl_a, fl_b);
            r.z  = (r.d == '0);
            exp_q.push_back(r);
            infl = 1'b0;
        end
        if (g >= 0) begin
            infl  = 1'b1;
            fl_id = g;
            fl_op = r_op[g];
            fl_a  = r_a[g];
            fl_b  = r_b[g];
            acc[g] = 1'b1;
            if (!(PRIO && g == 0)) ptr = (g + 1) % N;
        end
    endtask

    // Apply requester / consumer behaviour for the coming cycle.
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            logic w;
            if (acc[i]) r_v[i] = 1'b0;
            w = rnd_want ? (($urandom % 4) != 0) : want[i];
            if (!w) begin
                r_v[i] = 1'b0;
            end else if (!r_v[i]) begin
                r_v[i] = 1'b1;
                if (fixed) begin
                    r_op[i] = fx_op[i];
                    r_a[i]  = fx_a[i];
                    r_b[i]  = fx_b[i];
                end else begin
                    r_op[i] = OW'($urandom);
                    r_a[i]  = W'($urandom);
                    r_b[i]  = (($urandom % 4) == 0) ? r_a[i] : W'($urandom);
                end
            end
        end
        rsp_ready = rnd_rdy ? (($urandom % 3) != 0) : rdy_val;
        acc = '0;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            model_cycle();
            @(posedge clk);
            #1;
            drive();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_RspValid", 32'(rsp_valid), 0);
        check_eq("rst_RspId", 32'(rsp_id), 0);
        check_eq("rst_RspData", 32'(rsp_data), 0);
        check_eq("rst_RspZero", 32'(rsp_zero), 0);
        check_eq("rst_AluOp", 32'(alu_op), 0);
        check_eq("rst_AluA", 32'(alu_a), 0);
        check_eq("rst_AluB", 32'(alu_b), 0);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic quiesce();
        want = '0;
        rnd_want = 1'b0;
        rdy_val = 1'b1;
        drive();
        run(4);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        r_v = '0;
        for (int i = 0; i < N; i++) begin
            r_op[i] = '0; r_a[i] = '0; r_b[i] = '0;
            fx_op[i] = '0; fx_a[i] = '0; fx_b[i] = '0;
        end
        want = '0; acc = '0;
        rnd_want = 1'b0; rnd_rdy = 1'b0; fixed = 1'b1; rdy_val = 1'b1;
        rsp_ready = 1'b1;
        model_reset();
        do_reset();

        // Single request from requester 0: 30 + 3
        fx_op[0] = 3'd0; fx_a[0] = 16'd30; fx_b[0] = 16'd3;
        want = 3'b001;
        drive();
        run(1);
        want = 3'b000;
        drive();
        run(4);

        // Two requesters always valid, consumer always ready
        fx_op[0] = 3'd0; fx_a[0] = -16'sd10; fx_b[0] = 16'd2;
        fx_op[1] = 3'd0; fx_a[1] = 16'd10;   fx_b[1] = -16'sd4;
        want = 3'b011;
        drive();
        run(12);

        // Consumer stalls with a response pending, then resumes
        rdy_val = 1'b0;
        drive();
        run(7);
        rdy_val = 1'b1;
        drive();
        run(6);
        quiesce();

        // Zero / non-zero results: -1 - -1 and 5 + 7
        fx_op[0] = 3'd1; fx_a[0] = 16'hFFFF; fx_b[0] = 16'hFFFF;
        fx_op[1] = 3'd0; fx_a[1] = 16'd5;    fx_b[1] = 16'd7;
        want = 3'b011;
        drive();
        run(10);

        // Reset while an op is on the ALU; it must never respond
        for (int t = 0; t < 50 && !infl; t++) run(1);
        check_eq("reach_issue", 32'(infl), 1);
        #1 rst = 1'b1;
        #1;
        check_eq("midrst_AluA", 32'(alu_a), 0);
        check_eq("midrst_AluB", 32'(alu_b), 0);
        check_eq("midrst_AluOp", 32'(alu_op), 0);
        check_eq("midrst_RspValid", 32'(rsp_valid), 0);
        check_eq("midrst_RspData", 32'(rsp_data), 0);
        #1 rst = 1'b0;
        model_reset();
        fixed = 1'b0;
        r_v = '0;
        want = 3'b110;
        drive();
        run(10);
        quiesce();

        // All three valid, then requester 0 drops out
        fixed = 1'b1;
        for (int i = 0; i < N; i++) begin
            fx_op[i] = OW'($urandom); fx_a[i] = W'($urandom); fx_b[i] = W'($urandom);
        end
        want = 3'b111;
        drive();
        run(14);
        want = 3'b110;
        drive();
        run(14);
        quiesce();

        // Random traffic with random drops and consumer backpressure
        fixed = 1'b0;
        rnd_want = 1'b1;
        rnd_rdy = 1'b1;
        drive();
        run(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
